nios_system_nios2_gen_0_cpu_debug_host_scan: RTL and testbench
==============================================================

Name: nios_system_nios2_gen_0_cpu_debug_host_scan

Overview:
Host-side scan initiator for the Nios II debug slave's virtual-JTAG interface. It drives the other end of the vji_* signal set that the debug slave wrapper consumes. It accepts a command containing a 2-bit IR and a 38-bit DR payload, then plays the sequence UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI on a divided tck. Data is shifted LSB-first on tdi, and tdo is captured into a response word. It is used by on-chip debug bring-up logic and simulation benches in place of the sld_virtual_jtag_basic hub.

Parameters:
- DR_WIDTH, 38: scan-chain length in bits. Minimum 2.
- IR_WIDTH, 2: virtual IR width.
- CLK_DIV, 4: clk cycles per tck period. Must be even and at least 2.
- RTI_PERIODS, 1: tck periods spent in RTI after UDR. Minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_ir  in  IR_WIDTH  IR value to present on vji_ir_in.
- cmd_dr  in  DR_WIDTH  DR payload, shifted out LSB-first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_WIDTH  captured tdo bits; bit 0 is the first bit shifted out.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_tck  out  1  divided scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  IR value presented to the slave.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state indicators; at most one is high at any time.

Behaviour:
- Reset:
  - Asynchronous assertion forces all outputs to 0, including cmd_ready, rsp_dr and rsp_ir_out.
  - The FSM returns to IDLE. A scan in progress is abandoned with no response.
  - After deassertion, cmd_ready rises on the first clk edge.
- FSM states and transitions:
  - IDLE -> UIR on accept.
  - UIR -> CDR, CDR -> SDR: 1 tck period each.
  - SDR -> UDR: after DR_WIDTH tck periods.
  - UDR -> RTI: 1 tck period.
  - RTI -> RESP: after RTI_PERIODS tck periods.
  - RESP -> IDLE: on rsp_ready.
- Period timing:
  - Each tck period is CLK_DIV clk cycles. vji_tck is low for the first CLK_DIV/2 cycles and high for the rest.
  - State outputs and vji_tdi change only at a period boundary, which is a tck falling edge.
  - The divider counter runs only outside IDLE and RESP. In those two states vji_tck is held at 0.
- Accept:
  - cmd_ready = (state==IDLE).
  - On accept, latch cmd_ir into vji_ir_in and cmd_dr into the shift register.
  - vji_ir_in holds its value until the next accept.
- Capture:
  - rsp_ir_out samples vji_ir_out at the clk edge where tck rises in the UIR period.
- Shift (SDR):
  - vji_tdi = shift[0].
  - vji_tdo is sampled at the tck rising point.
  - At the period end, shift <= {tdo_sample, shift[DR_WIDTH-1:1]}.
  - After DR_WIDTH periods the shift register holds exactly the captured bits.
- Response:
  - Entering RESP loads rsp_dr from the shift register and sets rsp_valid.
  - rsp_valid is held until rsp_ready; rsp_dr and rsp_ir_out stay stable while rsp_valid is high.
  - A new command is refused until rsp_ready is seen, because cmd_ready stays 0 in RESP.
- Latency: from accept to rsp_valid = (3 + DR_WIDTH + RTI_PERIODS) * CLK_DIV clk cycles. With defaults this is 42 * 4 = 168 cycles.
- Boundaries:
  - cmd_valid while busy has no effect, and cmd_dr changes while busy are ignored.
  - rsp_ready while rsp_valid is low is ignored.
  - rsp_ready in the same cycle rsp_valid rises means IDLE is reached on the next cycle.
  - The counter wraps from CLK_DIV-1 to 0. The bit counter is ceil(log2(DR_WIDTH+1)) bits wide.

Decomposition:
- Shared package nios_system_nios2_gen_0_cpu_debug_host_pkg holds:
  - state enum (IDLE, UIR, CDR, SDR, UDR, RTI, RESP);
  - IR command constants IR_OCIMEM_A=2'b00, IR_OCIMEM_B=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11;
  - DR_WIDTH default.
- One sub-module, nios_system_nios2_gen_0_cpu_debug_host_tck_gen, outputs vji_tck, rise_pulse and period_end_pulse, with an enable input.

Test Plan:
- Reset mid-SDR (bit 10 of 38) -> within the same clk edge all vji_* outputs are 0, no rsp_valid follows, and cmd_ready=1 on the first edge after deassertion.
- Single command, loopback (vji_tdo = delayed 38-bit slave model, slave sr preloaded 38'h2A_DEAD_BEEF), cmd_ir=2'b10, cmd_dr=38'h15_1234_5678 -> the slave sees ir_in=2'b10 and sr==38'h15_1234_5678 at UDR; rsp_dr=38'h2A_DEAD_BEEF; rsp_valid exactly 168 clks after accept.
- Waveform check with CLK_DIV=2 -> vji_tck toggles every clk; one uir pulse (1 period), one cdr, exactly 38 sdr periods, one udr, one rti; no two state strobes overlap.
- Backpressure: hold rsp_ready=0 for 50 clks and assert cmd_valid with new data -> cmd_ready stays 0, rsp_dr is unchanged, no tck activity; after rsp_ready=1, the next command is accepted one clk later.
- vji_ir_out=2'b01 during UIR, 2'b11 otherwise -> rsp_ir_out=2'b01.
- Back-to-back commands with rsp_ready tied high -> the second command is accepted 2 clks after rsp_valid; both responses are correct; vji_ir_in switches only at accept.

Source files
------------

// File: rtl/nios_system_nios2_gen_0_cpu_debug_host_pkg.sv
// Shared types and constants for the Nios II debug host-side scan initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_system_nios2_gen_0_cpu_debug_host_pkg;

    // Virtual-JTAG sequence walked for every command.
    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI,
        RESP
    } host_state_t;

    // Virtual IR encodings understood by the debug slave.
    localparam logic [1:0] IR_OCIMEM_A  = 2'b00;
    localparam logic [1:0] IR_OCIMEM_B  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // Length of the debug slave's data register chain.
    localparam int DEBUG_DR_WIDTH = 38;

endpackage

// File: rtl/nios_system_nios2_gen_0_cpu_debug_host_tck_gen.sv
// Scan clock divider: one tck period every CLK_DIV clk cycles, low half first.
// Latency: tck and pulses derive from a registered counter; counter starts at 0 the cycle after i_en rises.
// Backpressure: none; when i_en is low the counter is held at 0 and tck at 0.
//
// Ports: clk/reset_n system clock and async active-low reset; i_en runs the divider;
//        o_tck divided clock; o_rise_pulse high in the cycle whose closing edge raises tck;
//        o_period_end_pulse high in the last cycle of a period (closing edge drops tck).
module nios_system_nios2_gen_0_cpu_debug_host_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_pulse,
    output logic o_period_end_pulse
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_tck;

    always_comb begin
        w_cnt_nxt = '0;
        if (i_en && (r_cnt != LAST)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // tck is registered from the next count so it never glitches on multi-bit counter steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tck <= (w_cnt_nxt >= HALF);
        end
    end

    assign o_tck              = r_tck;
    assign o_rise_pulse       = i_en && (r_cnt == HALF_M1);
    assign o_period_end_pulse = i_en && (r_cnt == LAST);

endmodule

// File: rtl/nios_system_nios2_gen_0_cpu_debug_host_scan.sv
// Host-side virtual-JTAG scan initiator: plays UIR, CDR, SDR x DR_WIDTH, UDR, RTI for each command.
// Latency: accept to rsp_valid is (3 + DR_WIDTH + RTI_PERIODS) * CLK_DIV clk cycles.
// Backpressure: cmd_ready is low while a scan runs and while a response waits for rsp_ready.
//
// Ports: clk/reset_n; cmd_valid/cmd_ready/cmd_ir/cmd_dr command in; rsp_valid/rsp_ready/rsp_dr/
//        rsp_ir_out response out; vji_* drive the debug slave (tck, tdi, ir_in, state strobes)
//        and return its tdo and ir_out.
module nios_system_nios2_gen_0_cpu_debug_host_scan
    import nios_system_nios2_gen_0_cpu_debug_host_pkg::*;
#(
    parameter int DR_WIDTH    = DEBUG_DR_WIDTH,
    parameter int IR_WIDTH    = 2,
    parameter int CLK_DIV     = 4,
    parameter int RTI_PERIODS = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam int RW = (RTI_PERIODS > 1) ? $clog2(RTI_PERIODS + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
    localparam logic [RW-1:0] RTI_LAST = RW'(RTI_PERIODS - 1);

    host_state_t         r_state;
    host_state_t         w_state_nxt;
    logic                r_init;      // keeps cmd_ready low until the first edge after reset
    logic [DR_WIDTH-1:0] r_shift;
    logic                r_tdo_smp;
    logic [BW-1:0]       r_bit_cnt;
    logic [RW-1:0]       r_rti_cnt;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_rsp_ir;

    logic w_en;
    logic w_tck;
    logic w_rise;
    logic w_pend;
    logic w_accept;
    logic w_uir, w_cdr, w_sdr, w_udr, w_rti, w_resp;

    nios_system_nios2_gen_0_cpu_debug_host_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_en               (w_en),
        .o_tck              (w_tck),
        .o_rise_pulse       (w_rise),
        .o_period_end_pulse (w_pend)
    );

    assign w_en      = (r_state != IDLE) && (r_state != RESP);
    assign cmd_ready = r_init && (r_state == IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_uir  = 1'b0;
        w_cdr  = 1'b0;
        w_sdr  = 1'b0;
        w_udr  = 1'b0;
        w_rti  = 1'b0;
        w_resp = 1'b0;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = UIR;
            UIR: begin
                w_uir = 1'b1;
                if (w_pend) w_state_nxt = CDR;
            end
            CDR: begin
                w_cdr = 1'b1;
                if (w_pend) w_state_nxt = SDR;
            end
            SDR: begin
                w_sdr = 1'b1;
                if (w_pend && (r_bit_cnt == BIT_LAST)) w_state_nxt = UDR;
            end
            UDR: begin
                w_udr = 1'b1;
                if (w_pend) w_state_nxt = RTI;
            end
            RTI: begin
                w_rti = 1'b1;
                if (w_pend && (r_rti_cnt == RTI_LAST)) w_state_nxt = RESP;
            end
            RESP: begin
                w_resp = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_init    <= 1'b0;
            r_shift   <= '0;
            r_tdo_smp <= 1'b0;
            r_bit_cnt <= '0;
            r_rti_cnt <= '0;
            r_ir_in   <= '0;
            r_rsp_dr  <= '0;
            r_rsp_ir  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;

            if (w_accept) begin
                r_ir_in <= cmd_ir;
                r_shift <= cmd_dr;
            end

            if (w_uir && w_rise) begin
                r_rsp_ir <= vji_ir_out;
            end

            // tdo is taken at the tck rise and merged in at the following falling edge,
            // so after DR_WIDTH periods the register holds only captured bits.
            if (w_sdr && w_rise) begin
                r_tdo_smp <= vji_tdo;
            end
            if (w_sdr && w_pend) begin
                r_shift   <= {r_tdo_smp, r_shift[DR_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end else if (!w_sdr) begin
                r_bit_cnt <= '0;
            end

            if (w_rti && w_pend) begin
                r_rti_cnt <= r_rti_cnt + RW'(1);
                if (r_rti_cnt == RTI_LAST) begin
                    r_rsp_dr <= r_shift;
                end
            end else if (!w_rti) begin
                r_rti_cnt <= '0;
            end
        end
    end

    assign rsp_valid  = w_resp;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir;
    assign vji_tck    = w_tck;
    assign vji_tdi    = w_sdr && r_shift[0];
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = w_uir;
    assign vji_cdr    = w_cdr;
    assign vji_sdr    = w_sdr;
    assign vji_udr    = w_udr;
    assign vji_rti    = w_rti;

endmodule

// File: tb/tb_nios_system_nios2_gen_0_cpu_debug_host_scan.sv
// Bench for the debug host scan initiator: default instance with a loopback slave model,
// plus a CLK_DIV=2 instance for waveform checks.
// Directed vectors with hand-computed expectations.
module tb_nios_system_nios2_gen_0_cpu_debug_host_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_dr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_dr;
    logic [1:0]  rsp_ir_out;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic [1:0]  vji_ir_in, vji_ir_out;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2, rsp_valid2;
    logic [37:0] rsp_dr2;
    logic [1:0]  rsp_ir2, ir_in2;
    logic        tck2, tdi2, uir2, cdr2, sdr2, udr2, rti2;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    nios_system_nios2_gen_0_cpu_debug_host_scan u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    nios_system_nios2_gen_0_cpu_debug_host_scan #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_dr(rsp_dr2), .rsp_ir_out(rsp_ir2),
        .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(1'b0),
        .vji_ir_in(ir_in2), .vji_ir_out(2'b00),
        .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2), .vji_udr(udr2), .vji_rti(rti2)
    );

    // Slave model: loads its preload at CDR, shifts LSB-first in SDR, records what it saw at UDR.
    logic [37:0] slave_sr = '0;
    logic [37:0] slave_preload = '0;
    logic [37:0] slave_seen_sr = '0;
    logic [1:0]  slave_seen_ir = '0;

    always @(posedge vji_tck) begin
        if (vji_cdr) slave_sr <= slave_preload;
        else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[37:1]};
        if (vji_udr) begin
            slave_seen_sr <= slave_sr;
            slave_seen_ir <= vji_ir_in;
        end
    end

    assign vji_tdo    = slave_sr[0];
    assign vji_ir_out = vji_uir ? 2'b01 : 2'b11;

    // Issues one command on the default instance and returns clk cycles from accept to
    // rsp_valid, or -1 if the response never arrives.
    task automatic send_and_wait(input logic [1:0] ir, input logic [37:0] dr, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_ir = ir;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_dr = ~dr;
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b want 0 0", cmd_ready, rsp_valid);
        end
        n_cmp++;
        if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_vji: got %b want 0", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        end
        n_cmp++;
        if (rsp_dr !== 38'h0 || rsp_ir_out !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_rsp: rsp_dr=%h rsp_ir_out=%b want 0", rsp_dr, rsp_ir_out);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rdy_before_edge: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy_after_edge: got %b/%b want 1/1", cmd_ready, cmd_ready2);
        end
    endtask

    task automatic test_loopback();
        int lat;
        slave_preload = 38'h2A_DEAD_BEEF;
        rsp_ready = 1'b0;
        send_and_wait(2'b10, 38'h15_1234_5678, lat);
        n_cmp++;
        if (lat != 168) begin
            n_bad++;
            $display("FAIL loop_latency: got %0d want 168", lat);
        end
        n_cmp++;
        if (rsp_dr !== 38'h2A_DEAD_BEEF) begin
            n_bad++;
            $display("FAIL loop_rsp_dr: got %h want 2adeadbeef", rsp_dr);
        end
        n_cmp++;
        if (rsp_ir_out !== 2'b01) begin
            n_bad++;
            $display("FAIL loop_rsp_ir: got %b want 01", rsp_ir_out);
        end
        n_cmp++;
        if (slave_seen_sr !== 38'h15_1234_5678) begin
            n_bad++;
            $display("FAIL loop_slave_sr: got %h want 1512345678", slave_seen_sr);
        end
        n_cmp++;
        if (slave_seen_ir !== 2'b10 || vji_ir_in !== 2'b10) begin
            n_bad++;
            $display("FAIL loop_ir_in: slave saw %b, ir_in %b, want 10", slave_seen_ir, vji_ir_in);
        end
    endtask

    // Runs with the previous response still pending.
    task automatic test_backpressure();
        int bp_err;
        int lat;
        bp_err = 0;
        slave_preload = 38'h3F_0F0F_0F0F;
        cmd_ir = 2'b01;
        cmd_dr = 38'h0A_5555_AAAA;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || vji_tck !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_dr !== 38'h2A_DEAD_BEEF || vji_ir_in !== 2'b10) bp_err++;
        end
        n_cmp++;
        if (bp_err != 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d bad cycles want 0", bp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_dr = 38'h0;
        n_cmp++;
        if (cmd_ready !== 1'b0 || vji_ir_in !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_accept: cmd_ready=%b ir_in=%b want 0 01", cmd_ready, vji_ir_in);
        end
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 168 || rsp_dr !== 38'h3F_0F0F_0F0F) begin
            n_bad++;
            $display("FAIL bp_second_rsp: lat=%0d rsp_dr=%h want 168 3f0f0f0f0f", lat, rsp_dr);
        end
        n_cmp++;
        if (slave_seen_sr !== 38'h0A_5555_AAAA) begin
            n_bad++;
            $display("FAIL bp_busy_dr_ignored: slave saw %h want 0a5555aaaa", slave_seen_sr);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_sdr();
        int guard;
        int bad;
        slave_preload = 38'h00_1111_2222;
        cmd_ir = 2'b11;
        cmd_dr = 38'h1;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!vji_sdr && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (41) @(negedge clk);
        n_cmp++;
        if (vji_sdr !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_in_sdr: sdr=%b want 1", vji_sdr);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 10'b0 ||
            cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: vji=%b rdy=%b rv=%b want 0", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, cmd_ready, rsp_valid);
        end
        n_cmp++;
        if (rsp_dr !== 38'h0 || rsp_ir_out !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_rsp: rsp_dr=%h rsp_ir=%b want 0", rsp_dr, rsp_ir_out);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready: got %b want 1", cmd_ready);
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || vji_tck !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL rst_mid_no_rsp: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_waveform();
        int lat, ovl, tck_err, rises, tdi_hi;
        int n_uir, n_cdr, n_sdr, n_udr, n_rti, s;
        logic exp_tck, prev_uir;
        lat = 0; ovl = 0; tck_err = 0; rises = 0; tdi_hi = 0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        exp_tck = 1'b0;
        prev_uir = 1'b0;
        cmd_ir = 2'b00;
        cmd_dr = 38'h2_AAAA_5555;
        @(negedge clk);
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        while (!rsp_valid2 && lat < 300) begin
            s = int'(uir2) + int'(cdr2) + int'(sdr2) + int'(udr2) + int'(rti2);
            if (s != 1) ovl++;
            if (tck2 !== exp_tck) tck_err++;
            exp_tck = ~exp_tck;
            if (uir2 && !prev_uir) rises++;
            prev_uir = uir2;
            n_uir += int'(uir2);
            n_cdr += int'(cdr2);
            n_sdr += int'(sdr2);
            n_udr += int'(udr2);
            n_rti += int'(rti2);
            tdi_hi += int'(tdi2);
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 84) begin
            n_bad++;
            $display("FAIL wave_latency: got %0d want 84", lat);
        end
        n_cmp++;
        if (n_uir != 2 || n_cdr != 2 || n_sdr != 76 || n_udr != 2 || n_rti != 2 || rises != 1) begin
            n_bad++;
            $display("FAIL wave_strobes: uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d uir_pulses=%0d want 2 2 76 2 2 1", n_uir, n_cdr, n_sdr, n_udr, n_rti, rises);
        end
        n_cmp++;
        if (ovl != 0 || tck_err != 0 || tck2 !== 1'b0) begin
            n_bad++;
            $display("FAIL wave_tck: overlap=%0d tck_err=%0d tck_in_resp=%b want 0 0 0", ovl, tck_err, tck2);
        end
        n_cmp++;
        if (tdi_hi != 34 || rsp_dr2 !== 38'h0 || rsp_ir2 !== 2'b00 || ir_in2 !== 2'b00) begin
            n_bad++;
            $display("FAIL wave_data: tdi_hi=%0d rsp_dr=%h rsp_ir=%b ir_in=%b want 34 0 00 00", tdi_hi, rsp_dr2, rsp_ir2, ir_in2);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cnt, rv_cnt, t_rv1, t_acc2, ir_err, guard;
        logic acc_prev, acc_now;
        logic [1:0]  prev_ir;
        logic [37:0] r1, r2;
        acc_cnt = 0; rv_cnt = 0; t_rv1 = -1; t_acc2 = -1; ir_err = 0; guard = 0;
        acc_prev = 1'b0;
        r1 = '0; r2 = '0;
        rsp_ready = 1'b1;
        slave_preload = 38'h01_2345_6789;
        @(negedge clk);
        cmd_ir = 2'b11;
        cmd_dr = 38'h20_0000_0001;
        cmd_valid = 1'b1;
        prev_ir = vji_ir_in;
        while (rv_cnt < 2 && guard < 600) begin
            if (vji_ir_in !== prev_ir && !acc_prev) ir_err++;
            prev_ir = vji_ir_in;
            if (acc_prev && acc_cnt == 1) begin
                cmd_ir = 2'b01;
                cmd_dr = 38'h1F_8000_0003;
            end else if (acc_prev && acc_cnt == 2) begin
                cmd_valid = 1'b0;
            end
            if (rsp_valid) begin
                rv_cnt++;
                if (rv_cnt == 1) begin
                    t_rv1 = cyc;
                    r1 = rsp_dr;
                    slave_preload = 38'h30_CAFE_F00D;
                end else begin
                    r2 = rsp_dr;
                end
            end
            acc_now = cmd_valid && cmd_ready;
            if (acc_now) begin
                acc_cnt++;
                if (acc_cnt == 2) t_acc2 = cyc + 1;
            end
            acc_prev = acc_now;
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (t_acc2 - t_rv1 != 2 || t_rv1 < 0) begin
            n_bad++;
            $display("FAIL b2b_gap: accept2-rsp_valid1 = %0d want 2", t_acc2 - t_rv1);
        end
        n_cmp++;
        if (r1 !== 38'h01_2345_6789 || r2 !== 38'h30_CAFE_F00D) begin
            n_bad++;
            $display("FAIL b2b_rsp: got %h %h want 0123456789 30cafef00d", r1, r2);
        end
        n_cmp++;
        if (ir_err != 0 || vji_ir_in !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_ir_in: stray changes=%0d ir_in=%b want 0 01", ir_err, vji_ir_in);
        end
        n_cmp++;
        if (slave_seen_sr !== 38'h1F_8000_0003 || slave_seen_ir !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_slave: sr=%h ir=%b want 1f80000003 01", slave_seen_sr, slave_seen_ir);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_backpressure();
        test_reset_mid_sdr();
        test_waveform();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
